nibble_serial_adder: RTL and testbench

Multi-cycle WIDTH-bit adder that processes one 4-bit nibble per clock, LSB nibble first, through a 4-bit ripple-carry stage. The carry is kept in a register between cycles. It sits directly upstream of the 4-bit adder slice: it slices the operands into nibbles, feeds the slice, and collects the sum nibbles and final carry. Intended for area-lean datapaths where latency is acceptable.

---
 rtl/nibble_serial_adder_pkg.sv | 19 +
 rtl/nibble_serial_adder_nibble_add4.sv | 27 ++
 rtl/nibble_serial_adder.sv | 113 +++++++++++
 tb/tb_nibble_serial_adder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: state encodings and nibble width.
package nibble_serial_adder_pkg;

  // Bits handled by the adder slice each cycle.
  localparam int unsigned NIB_W = 4;

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One full-adder bit: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    full_add = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

endpackage : nibble_serial_adder_pkg

// File: rtl/nibble_serial_adder_nibble_add4.sv
// Combinational 4-bit ripple-carry adder slice built from per-bit full adders.
module nibble_add4
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  // Ripple the carry through each bit position, LSB first.
  always_comb begin
    logic       c;
    logic [1:0] fa;
    s  = '0;
    c  = cin;
    fa = '0;
    for (int i = 0; i < int'(NIB_W); i++) begin
      fa   = full_add(a[i], b[i], c);
      s[i] = fa[0];
      c    = fa[1];
    end
    cout = c;
  end

endmodule : nibble_add4

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock, LSB first, through a shared 4-bit slice.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               carry;
  logic [IDX_W-1:0]   idx;

  logic [NIB_W-1:0]   a_nib;
  logic [NIB_W-1:0]   b_nib;
  logic [NIB_W-1:0]   s4;
  logic               c4;

  // Select the operand nibbles addressed by idx for the adder slice.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < int'(NIB); i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = a_r[i*NIB_W +: NIB_W];
        b_nib = b_r[i*NIB_W +: NIB_W];
      end
    end
  end

  nibble_add4 u_add4 (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .s    (s4),
    .cout (c4)
  );

  // Controller, operand capture and result collection; all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        S_RUN: begin
          for (int i = 0; i < int'(NIB); i++) begin
            if (idx == IDX_W'(i)) begin
              sum[i*NIB_W +: NIB_W] <= s4;
            end
          end
          carry <= c4;
          if (idx == IDX_LAST) begin
            // Last nibble: publish the carry-out and park idx at zero.
            cout  <= c4;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (WIDTH=16).
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Full operation from accept to done, then one idle cycle.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tc, input logic [15:0] es, input logic ec);
    int busy_cnt;
    busy_cnt = 0;
    a = ta; b = tb; cin = tc; start = 1'b1;
    edge1();
    start = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      if (busy) busy_cnt++;
      chk({tag, "_done_low"}, 32'(done), 32'd0);
      edge1();
    end
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    edge1();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_sum_hold"}, 32'(sum), 32'(es));
    chk({tag, "_cout_hold"}, 32'(cout), 32'(ec));
  endtask

  initial begin
    int pulses;
    logic [15:0] got;

    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) edge1();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    reset = 1'b0;
    edge1();
    chk("idle_busy", 32'(busy), 32'd0);

    // Basic add and saturation cases.
    run_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    run_op("sat",   16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    run_op("msb",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

    // Full carry ripple with the internal carry observed after E1..E3.
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    edge1();
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      edge1();
      chk($sformatf("ripple_carry_E%0d", i), 32'(dut.carry), 32'd1);
      chk($sformatf("ripple_sum_E%0d", i), 32'(sum), 32'd0);
    end
    edge1();
    chk("ripple_done", 32'(done), 32'd1);
    chk("ripple_sum",  32'(sum),  32'h0000);
    chk("ripple_cout", 32'(cout), 32'd1);
    edge1();

    // Start while busy is ignored.
    a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
    edge1();
    start = 1'b0;
    edge1();
    a = 16'hAAAA; b = 16'h5555; start = 1'b1;
    edge1();
    start = 1'b0;
    chk("ignore_busy", 32'(busy), 32'd1);
    pulses = 0;
    got = '0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        pulses++;
        got = sum;
      end
      edge1();
    end
    chk("ignore_pulses", 32'(pulses), 32'd1);
    chk("ignore_sum",    32'(got),    32'h0002);
    chk("ignore_cout",   32'(cout),   32'd0);

    // Back-to-back: new start during the DONE cycle.
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    edge1();
    start = 1'b0;
    repeat (4) edge1();
    chk("b2b_first_done", 32'(done), 32'd1);
    chk("b2b_first_sum",  32'(sum),  32'h5555);
    a = 16'h00FF; b = 16'h0001; start = 1'b1;
    edge1();
    start = 1'b0;
    chk("b2b_rerun_busy", 32'(busy), 32'd1);
    chk("b2b_rerun_done", 32'(done), 32'd0);
    chk("b2b_rerun_sum",  32'(sum),  32'h0000);
    repeat (4) edge1();
    chk("b2b_second_done", 32'(done), 32'd1);
    chk("b2b_second_sum",  32'(sum),  32'h0100);
    chk("b2b_second_cout", 32'(cout), 32'd0);
    edge1();

    // Reset mid-operation clears everything without a clock edge.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    edge1();
    start = 1'b0;
    repeat (2) edge1();
    chk("midrst_partial", 32'(sum), 32'h0033);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum",  32'(sum),  32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    edge1();
    reset = 1'b0;
    edge1();
    run_op("postrst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_nibble_serial_adder
